// File: rtl/writeback_stage_pkg.sv
// Shared widths, condition-code encodings, link register and FSM states for the writeback stage.
package writeback_stage_pkg;

  localparam int DEF_PC_WIDTH      = 16;
  localparam int DEF_REG_WIDTH     = 32;
  localparam int DEF_VREG_WIDTH    = 64;
  localparam int DEF_VREG_ID_WIDTH = 6;
  localparam int DEF_RCNT_WIDTH    = 32;

  localparam logic [2:0] CC_NONE = 3'b000;
  localparam logic [2:0] CC_N    = 3'b100;
  localparam logic [2:0] CC_Z    = 3'b010;
  localparam logic [2:0] CC_P    = 3'b001;

  localparam logic [3:0] LINK_REG = 4'd7;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_REDIRECT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM/WB latch inputs and Decode-facing writeback outputs. O_RetireCount exists only with
// WB_RETIRE_COUNT_EN defined.
interface writeback_stage_if
  import writeback_stage_pkg::*;
#(
  parameter int PC_WIDTH      = DEF_PC_WIDTH,
  parameter int REG_WIDTH     = DEF_REG_WIDTH,
  parameter int VREG_WIDTH    = DEF_VREG_WIDTH,
  parameter int VREG_ID_WIDTH = DEF_VREG_ID_WIDTH
`ifdef WB_RETIRE_COUNT_EN
  ,
  parameter int RCNT_WIDTH    = DEF_RCNT_WIDTH
`endif
);

  logic                     I_LOCK;
  logic                     I_MW_Valid;
  logic [PC_WIDTH-1:0]      I_PC;
  logic [REG_WIDTH-1:0]     I_ALUOut;
  logic [REG_WIDTH-1:0]     I_MemOut;
  logic [VREG_WIDTH-1:0]    I_VecValue;
  logic [3:0]               I_DestRegIdx;
  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx;
  logic                     I_RegWrite;
  logic                     I_VRegWrite;
  logic                     I_CCWrite;
  logic                     I_IsLoad;
  logic                     I_IsLink;
  logic                     I_IsFloat;
  logic                     I_Redirect;
  logic [PC_WIDTH-1:0]      I_RedirectPC;

  logic                     O_LOCK;
  logic [3:0]               O_WriteBackRegIdx;
  logic [VREG_ID_WIDTH-1:0] O_WriteBackVRegIdx;
  logic [REG_WIDTH-1:0]     O_WriteBackData;
  logic [VREG_WIDTH-1:0]    O_VecDestValue;
  logic                     O_RegWEn;
  logic                     O_VRegWEn;
  logic                     O_CCWEn;
  logic [2:0]               O_CCValue;
  logic [PC_WIDTH-1:0]      O_WriteBackPC;
  logic                     O_WriteBackPCEn;
`ifdef WB_RETIRE_COUNT_EN
  logic [RCNT_WIDTH-1:0]    O_RetireCount;
`endif

  // master: the MEM/WB latch side driving the stage (and observing its results)
  modport master (
    output I_LOCK, I_MW_Valid, I_PC, I_ALUOut, I_MemOut, I_VecValue, I_DestRegIdx,
           I_DestVRegIdx, I_RegWrite, I_VRegWrite, I_CCWrite, I_IsLoad, I_IsLink,
           I_IsFloat, I_Redirect, I_RedirectPC,
    input  O_LOCK, O_WriteBackRegIdx, O_WriteBackVRegIdx, O_WriteBackData, O_VecDestValue,
           O_RegWEn, O_VRegWEn, O_CCWEn, O_CCValue, O_WriteBackPC, O_WriteBackPCEn
`ifdef WB_RETIRE_COUNT_EN
           , O_RetireCount
`endif
  );

  modport slave (
    input  I_LOCK, I_MW_Valid, I_PC, I_ALUOut, I_MemOut, I_VecValue, I_DestRegIdx,
           I_DestVRegIdx, I_RegWrite, I_VRegWrite, I_CCWrite, I_IsLoad, I_IsLink,
           I_IsFloat, I_Redirect, I_RedirectPC,
    output O_LOCK, O_WriteBackRegIdx, O_WriteBackVRegIdx, O_WriteBackData, O_VecDestValue,
           O_RegWEn, O_VRegWEn, O_CCWEn, O_CCValue, O_WriteBackPC, O_WriteBackPCEn
`ifdef WB_RETIRE_COUNT_EN
           , O_RetireCount
`endif
  );

endinterface

// File: rtl/writeback_stage_cc_gen.sv
// wb_cc_gen: combinational {N,Z,P} from a result word; float mode treats +0 and -0 as zero.
module wb_cc_gen
  import writeback_stage_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH
) (
  input  logic [REG_WIDTH-1:0] d,
  input  logic                 is_float,
  output logic [2:0]           cc
);

  logic sign;
  logic is_zero;

  assign sign    = d[REG_WIDTH-1];
  assign is_zero = is_float ? (d[REG_WIDTH-2:0] == '0) : (d == '0);

  // Zero is tested first so a float -0 reports Z rather than N.
  assign cc = is_zero ? CC_Z : (sign ? CC_N : CC_P);

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: result select, registered RF write strobes, CC register and redirect pulse.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int PC_WIDTH      = DEF_PC_WIDTH,
  parameter int REG_WIDTH     = DEF_REG_WIDTH,
  parameter int VREG_WIDTH    = DEF_VREG_WIDTH,
  parameter int VREG_ID_WIDTH = DEF_VREG_ID_WIDTH
`ifdef WB_RETIRE_COUNT_EN
  ,
  parameter int RCNT_WIDTH    = DEF_RCNT_WIDTH
`endif
) (
  input logic              I_CLOCK,
  input logic              I_RESET_N,
  writeback_stage_if.slave wb
);

  logic                     retire;
  logic [REG_WIDTH-1:0]     sel_data;
  logic [3:0]               sel_idx;
  logic [2:0]               cc_calc;

  wb_state_e                state_q;
  wb_state_e                state_nxt;
  logic                     pc_en_nxt;

  logic                     lock_q;
  logic [3:0]               reg_idx_q;
  logic [VREG_ID_WIDTH-1:0] vreg_idx_q;
  logic [REG_WIDTH-1:0]     data_q;
  logic [VREG_WIDTH-1:0]    vec_q;
  logic                     reg_wen_q;
  logic                     vreg_wen_q;
  logic                     cc_wen_q;
  logic [2:0]               cc_q;
  logic [PC_WIDTH-1:0]      wb_pc_q;
  logic                     wb_pc_en_q;

  assign retire = wb.I_LOCK & wb.I_MW_Valid;

  // Link beats load beats ALU; the link value is the zero-extended return PC into R7.
  always_comb begin
    if (wb.I_IsLink) begin
      sel_data = {{(REG_WIDTH-PC_WIDTH){1'b0}}, wb.I_PC};
      sel_idx  = LINK_REG;
    end else if (wb.I_IsLoad) begin
      sel_data = wb.I_MemOut;
      sel_idx  = wb.I_DestRegIdx;
    end else begin
      sel_data = wb.I_ALUOut;
      sel_idx  = wb.I_DestRegIdx;
    end
  end

  wb_cc_gen #(
    .REG_WIDTH (REG_WIDTH)
  ) u_cc_gen (
    .d        (sel_data),
    .is_float (wb.I_IsFloat),
    .cc       (cc_calc)
  );

  // Redirect FSM: every retiring redirect yields exactly one pulse cycle; a stall freezes state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nxt = state_q;
    pc_en_nxt = 1'b0;
    if (wb.I_LOCK) begin
      unique case (state_q)
        WB_IDLE: begin
          if (retire && wb.I_Redirect) begin
            state_nxt = WB_REDIRECT;
            pc_en_nxt = 1'b1;
          end
        end
        WB_REDIRECT: begin
          if (retire && wb.I_Redirect) begin
            state_nxt = WB_REDIRECT;
            pc_en_nxt = 1'b1;
          end else begin
            state_nxt = WB_IDLE;
          end
        end
        default: state_nxt = WB_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= WB_IDLE;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_nxt;
    end
  end

  // Datapath: strobes follow retire each cycle; index/data/CC only move on a retire.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      lock_q     <= 1'b0;
      reg_idx_q  <= '0;
      vreg_idx_q <= '0;
      data_q     <= '0;
      vec_q      <= '0;
      reg_wen_q  <= 1'b0;
      vreg_wen_q <= 1'b0;
      cc_wen_q   <= 1'b0;
      cc_q       <= CC_NONE;
      wb_pc_q    <= '0;
      wb_pc_en_q <= 1'b0;
    end else begin
      lock_q     <= wb.I_LOCK;
      reg_wen_q  <= retire & wb.I_RegWrite;
      vreg_wen_q <= retire & wb.I_VRegWrite;
      cc_wen_q   <= retire & wb.I_CCWrite;
      wb_pc_en_q <= pc_en_nxt;
      if (retire) begin
        reg_idx_q  <= sel_idx;
        vreg_idx_q <= wb.I_DestVRegIdx;
        data_q     <= sel_data;
        vec_q      <= wb.I_VecValue;
        if (wb.I_CCWrite) begin
          cc_q <= cc_calc;
        end
      end
      if (pc_en_nxt) begin
        wb_pc_q <= wb.I_RedirectPC;
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  logic [RCNT_WIDTH-1:0] rcnt_q;

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      rcnt_q <= '0;
    end else if (retire) begin
      rcnt_q <= rcnt_q + 1'b1;
    end
  end

  assign wb.O_RetireCount = rcnt_q;
`endif

  assign wb.O_LOCK             = lock_q;
  assign wb.O_WriteBackRegIdx  = reg_idx_q;
  assign wb.O_WriteBackVRegIdx = vreg_idx_q;
  assign wb.O_WriteBackData    = data_q;
  assign wb.O_VecDestValue     = vec_q;
  assign wb.O_RegWEn           = reg_wen_q;
  assign wb.O_VRegWEn          = vreg_wen_q;
  assign wb.O_CCWEn            = cc_wen_q;
  assign wb.O_CCValue          = cc_q;
  assign wb.O_WriteBackPC      = wb_pc_q;
  assign wb.O_WriteBackPCEn    = wb_pc_en_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (retire counter checks need WB_RETIRE_COUNT_EN).
module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_rcnt = 0;

  writeback_stage_if bus ();

  writeback_stage dut (
    .I_CLOCK   (clk),
    .I_RESET_N (rst_n),
    .wb        (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.I_LOCK        = 1'b1;
    bus.I_MW_Valid    = 1'b0;
    bus.I_PC          = '0;
    bus.I_ALUOut      = '0;
    bus.I_MemOut      = '0;
    bus.I_VecValue    = '0;
    bus.I_DestRegIdx  = '0;
    bus.I_DestVRegIdx = '0;
    bus.I_RegWrite    = 1'b0;
    bus.I_VRegWrite   = 1'b0;
    bus.I_CCWrite     = 1'b0;
    bus.I_IsLoad      = 1'b0;
    bus.I_IsLink      = 1'b0;
    bus.I_IsFloat     = 1'b0;
    bus.I_Redirect    = 1'b0;
    bus.I_RedirectPC  = '0;
  endtask

  // One clock: count the expected retire, then sample 1 time unit after the edge.
  task automatic step();
    if (rst_n && bus.I_LOCK && bus.I_MW_Valid) exp_rcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (bus.O_RegWEn !== 1'b0) begin errors++; $display("FAIL reset_regwen got %0h exp 0", bus.O_RegWEn); end
    checks++; if (bus.O_WriteBackData !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.O_WriteBackData); end
    checks++; if (bus.O_CCValue !== 3'b000) begin errors++; $display("FAIL reset_cc got %b exp 000", bus.O_CCValue); end
    checks++; if (bus.O_WriteBackPCEn !== 1'b0) begin errors++; $display("FAIL reset_pcen got %0h exp 0", bus.O_WriteBackPCEn); end
    checks++; if (bus.O_LOCK !== 1'b0) begin errors++; $display("FAIL reset_lock got %0h exp 0", bus.O_LOCK); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    clear_inputs();
    bus.I_MW_Valid   = 1'b1;
    bus.I_ALUOut     = 32'hFFFF_FFF6;
    bus.I_DestRegIdx = 4'd3;
    bus.I_RegWrite   = 1'b1;
    bus.I_CCWrite    = 1'b1;
    step();
    checks++; if (bus.O_WriteBackRegIdx !== 4'd3) begin errors++; $display("FAIL add_idx got %0d exp 3", bus.O_WriteBackRegIdx); end
    checks++; if (bus.O_WriteBackData !== 32'hFFFF_FFF6) begin errors++; $display("FAIL add_data got %h exp FFFFFFF6", bus.O_WriteBackData); end
    checks++; if (bus.O_RegWEn !== 1'b1) begin errors++; $display("FAIL add_regwen got %0h exp 1", bus.O_RegWEn); end
    checks++; if (bus.O_CCWEn !== 1'b1) begin errors++; $display("FAIL add_ccwen got %0h exp 1", bus.O_CCWEn); end
    checks++; if (bus.O_CCValue !== 3'b100) begin errors++; $display("FAIL add_cc got %b exp 100", bus.O_CCValue); end
    checks++; if (bus.O_LOCK !== 1'b1) begin errors++; $display("FAIL add_lock got %0h exp 1", bus.O_LOCK); end
    clear_inputs();
    step();
    checks++; if (bus.O_RegWEn !== 1'b0) begin errors++; $display("FAIL idle_regwen got %0h exp 0", bus.O_RegWEn); end
    checks++; if (bus.O_CCWEn !== 1'b0) begin errors++; $display("FAIL idle_ccwen got %0h exp 0", bus.O_CCWEn); end
    checks++; if (bus.O_CCValue !== 3'b100) begin errors++; $display("FAIL idle_cc_hold got %b exp 100", bus.O_CCValue); end
    checks++; if (bus.O_WriteBackData !== 32'hFFFF_FFF6) begin errors++; $display("FAIL idle_data_hold got %h exp FFFFFFF6", bus.O_WriteBackData); end
  endtask

  task automatic test_load();
    clear_inputs();
    bus.I_MW_Valid   = 1'b1;
    bus.I_IsLoad     = 1'b1;
    bus.I_MemOut     = 32'h0;
    bus.I_ALUOut     = 32'h0000_1234;
    bus.I_DestRegIdx = 4'd5;
    bus.I_RegWrite   = 1'b1;
    bus.I_CCWrite    = 1'b1;
    step();
    checks++; if (bus.O_WriteBackData !== 32'h0) begin errors++; $display("FAIL load_data got %h exp 0", bus.O_WriteBackData); end
    checks++; if (bus.O_WriteBackRegIdx !== 4'd5) begin errors++; $display("FAIL load_idx got %0d exp 5", bus.O_WriteBackRegIdx); end
    checks++; if (bus.O_CCValue !== 3'b010) begin errors++; $display("FAIL load_cc got %b exp 010", bus.O_CCValue); end
  endtask

  task automatic test_jsr_back_to_back();
    clear_inputs();
    bus.I_MW_Valid   = 1'b1;
    bus.I_IsLink     = 1'b1;
    bus.I_IsLoad     = 1'b1;
    bus.I_MemOut     = 32'h5555_5555;
    bus.I_PC         = 16'h0040;
    bus.I_DestRegIdx = 4'd2;
    bus.I_RegWrite   = 1'b1;
    bus.I_Redirect   = 1'b1;
    bus.I_RedirectPC = 16'h0100;
    step();
    checks++; if (bus.O_WriteBackRegIdx !== 4'd7) begin errors++; $display("FAIL jsr_idx got %0d exp 7", bus.O_WriteBackRegIdx); end
    checks++; if (bus.O_WriteBackData !== 32'h0000_0040) begin errors++; $display("FAIL jsr_data got %h exp 00000040", bus.O_WriteBackData); end
    checks++; if (bus.O_RegWEn !== 1'b1) begin errors++; $display("FAIL jsr_regwen got %0h exp 1", bus.O_RegWEn); end
    checks++; if (bus.O_WriteBackPCEn !== 1'b1) begin errors++; $display("FAIL jsr_pcen got %0h exp 1", bus.O_WriteBackPCEn); end
    checks++; if (bus.O_WriteBackPC !== 16'h0100) begin errors++; $display("FAIL jsr_pc got %h exp 0100", bus.O_WriteBackPC); end
    clear_inputs();
    bus.I_MW_Valid   = 1'b1;
    bus.I_Redirect   = 1'b1;
    bus.I_RedirectPC = 16'h0200;
    step();
    checks++; if (bus.O_WriteBackPCEn !== 1'b1) begin errors++; $display("FAIL brz_pcen got %0h exp 1", bus.O_WriteBackPCEn); end
    checks++; if (bus.O_WriteBackPC !== 16'h0200) begin errors++; $display("FAIL brz_pc got %h exp 0200", bus.O_WriteBackPC); end
    checks++; if (bus.O_RegWEn !== 1'b0) begin errors++; $display("FAIL brz_regwen got %0h exp 0", bus.O_RegWEn); end
    clear_inputs();
    step();
    checks++; if (bus.O_WriteBackPCEn !== 1'b0) begin errors++; $display("FAIL redirect_end_pcen got %0h exp 0", bus.O_WriteBackPCEn); end
    checks++; if (bus.O_WriteBackPC !== 16'h0200) begin errors++; $display("FAIL redirect_pc_hold got %h exp 0200", bus.O_WriteBackPC); end
  endtask

  task automatic test_cc_rules();
    logic [31:0] vals [4];
    logic        flt  [4];
    logic [2:0]  exp  [4];
    vals = '{32'h0000_0005, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
    flt  = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp  = '{3'b001, 3'b100, 3'b100, 3'b010};
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      bus.I_MW_Valid = 1'b1;
      bus.I_ALUOut   = vals[i];
      bus.I_IsFloat  = flt[i];
      bus.I_CCWrite  = 1'b1;
      step();
      checks++; if (bus.O_CCValue !== exp[i]) begin errors++; $display("FAIL cmp_cc[%0d] got %b exp %b", i, bus.O_CCValue, exp[i]); end
      checks++; if (bus.O_RegWEn !== 1'b0) begin errors++; $display("FAIL cmp_regwen[%0d] got %0h exp 0", i, bus.O_RegWEn); end
      checks++; if (bus.O_CCWEn !== 1'b1) begin errors++; $display("FAIL cmp_ccwen[%0d] got %0h exp 1", i, bus.O_CCWEn); end
    end
  endtask

  task automatic test_vector();
    clear_inputs();
    bus.I_MW_Valid    = 1'b1;
    bus.I_ALUOut      = 32'h0000_0011;
    bus.I_VecValue    = 64'h0123_4567_89AB_CDEF;
    bus.I_DestVRegIdx = 6'h2A;
    bus.I_VRegWrite   = 1'b1;
    step();
    checks++; if (bus.O_VRegWEn !== 1'b1) begin errors++; $display("FAIL vec_wen got %0h exp 1", bus.O_VRegWEn); end
    checks++; if (bus.O_VecDestValue !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL vec_value got %h exp 0123456789ABCDEF", bus.O_VecDestValue); end
    checks++; if (bus.O_WriteBackVRegIdx !== 6'h2A) begin errors++; $display("FAIL vec_idx got %h exp 2a", bus.O_WriteBackVRegIdx); end
    checks++; if (bus.O_CCValue !== 3'b010) begin errors++; $display("FAIL vec_cc_hold got %b exp 010", bus.O_CCValue); end
  endtask

  task automatic test_lock();
    clear_inputs();
    bus.I_LOCK       = 1'b0;
    bus.I_MW_Valid   = 1'b1;
    bus.I_ALUOut     = 32'h0000_DEAD;
    bus.I_RegWrite   = 1'b1;
    bus.I_VRegWrite  = 1'b1;
    bus.I_CCWrite    = 1'b1;
    bus.I_Redirect   = 1'b1;
    bus.I_RedirectPC = 16'h0300;
    step();
    checks++; if (bus.O_LOCK !== 1'b0) begin errors++; $display("FAIL lock_out got %0h exp 0", bus.O_LOCK); end
    checks++; if ({bus.O_RegWEn, bus.O_VRegWEn, bus.O_CCWEn, bus.O_WriteBackPCEn} !== 4'b0000) begin
      errors++; $display("FAIL lock_strobes got %b exp 0000", {bus.O_RegWEn, bus.O_VRegWEn, bus.O_CCWEn, bus.O_WriteBackPCEn});
    end
    checks++; if (bus.O_WriteBackData !== 32'h0000_0011) begin errors++; $display("FAIL lock_data_hold got %h exp 00000011", bus.O_WriteBackData); end
    checks++; if (bus.O_WriteBackPC !== 16'h0200) begin errors++; $display("FAIL lock_pc_hold got %h exp 0200", bus.O_WriteBackPC); end
`ifdef WB_RETIRE_COUNT_EN
    checks++; if (bus.O_RetireCount !== 32'(exp_rcnt)) begin errors++; $display("FAIL lock_rcnt got %0d exp %0d", bus.O_RetireCount, exp_rcnt); end
`endif
    clear_inputs();
    step();
    checks++; if (bus.O_LOCK !== 1'b1) begin errors++; $display("FAIL unlock_out got %0h exp 1", bus.O_LOCK); end
  endtask

  task automatic test_reset_mid_run();
    clear_inputs();
    bus.I_MW_Valid   = 1'b1;
    bus.I_ALUOut     = 32'h0000_0005;
    bus.I_DestRegIdx = 4'd1;
    bus.I_RegWrite   = 1'b1;
    bus.I_CCWrite    = 1'b1;
    step();
    checks++; if (bus.O_RegWEn !== 1'b1) begin errors++; $display("FAIL pre_reset_regwen got %0h exp 1", bus.O_RegWEn); end
    checks++; if (bus.O_CCValue !== 3'b001) begin errors++; $display("FAIL pre_reset_cc got %b exp 001", bus.O_CCValue); end
    #2;
    rst_n    = 1'b0;
    exp_rcnt = 0;
    #1;
    checks++; if (bus.O_RegWEn !== 1'b0) begin errors++; $display("FAIL async_reset_regwen got %0h exp 0", bus.O_RegWEn); end
    checks++; if (bus.O_CCValue !== 3'b000) begin errors++; $display("FAIL async_reset_cc got %b exp 000", bus.O_CCValue); end
    checks++; if (bus.O_WriteBackData !== 32'h0) begin errors++; $display("FAIL async_reset_data got %h exp 0", bus.O_WriteBackData); end
    checks++; if (bus.O_WriteBackRegIdx !== 4'd0) begin errors++; $display("FAIL async_reset_idx got %0d exp 0", bus.O_WriteBackRegIdx); end
    checks++; if (bus.O_LOCK !== 1'b0) begin errors++; $display("FAIL async_reset_lock got %0h exp 0", bus.O_LOCK); end
`ifdef WB_RETIRE_COUNT_EN
    checks++; if (bus.O_RetireCount !== 32'd0) begin errors++; $display("FAIL async_reset_rcnt got %0d exp 0", bus.O_RetireCount); end
`endif
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.O_LOCK !== 1'b0) begin errors++; $display("FAIL post_release_lock got %0h exp 0", bus.O_LOCK); end
    step();
    checks++; if (bus.O_RegWEn !== 1'b0) begin errors++; $display("FAIL post_release_regwen got %0h exp 0", bus.O_RegWEn); end
    checks++; if (bus.O_CCValue !== 3'b000) begin errors++; $display("FAIL post_release_cc got %b exp 000", bus.O_CCValue); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load();
    test_jsr_back_to_back();
    test_cc_rules();
    test_vector();
    test_lock();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
